// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART receive path. Holds the parity
//               mode codes, the receiver state encoding and constant
//               functions that derive the tick divider and counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    // Clocks per oversampling tick.
    function automatic int calc_rate(input int clock_rate, input int baud_rate,
                                     input int ovr);
        return clock_rate / (baud_rate * ovr);
    endfunction

    // Bits needed to hold the values 0..n-1 (never less than one bit).
    function automatic int calc_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Free-running divider producing a one-clk tick every RATE
//               clocks, RATE = CLOCK_RATE / (BAUD_RATE * OVR).
// Ports       : clk   - system clock
//               rst_n - asynchronous active-low reset
//               tick  - one-clk pulse on each counter wrap
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVR        = 8
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int c_RATE = calc_rate(CLOCK_RATE, BAUD_RATE, OVR);
    localparam int c_CW   = calc_width(c_RATE);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_RATE - 1);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Parametrised UART receiver with majority-vote mid-bit
//               sampling, configurable data width / parity / stop bits,
//               break and overrun reporting and a valid/ready output.
// Ports       : clk        - system clock
//               rst_n      - asynchronous active-low reset
//               rx         - serial line (asynchronous, idles high)
//               data       - received word, LSB first on the line
//               valid      - word and flags held until accepted
//               ready      - consumer accepts when valid && ready
//               parity_err - parity mismatch on this word
//               frame_err  - a stop bit sampled low
//               brk        - word reports a break condition
//               overrun    - frames were dropped while this word was held
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVR        = 8,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 brk,
    output logic                 overrun
);

    localparam int c_TW = calc_width(OVR);
    localparam int c_BW = calc_width(DATA_BITS);
    localparam logic [c_TW-1:0] c_SAMP_A   = c_TW'(OVR/2 - 1);
    localparam logic [c_TW-1:0] c_SAMP_B   = c_TW'(OVR/2);
    localparam logic [c_TW-1:0] c_SAMP_C   = c_TW'(OVR/2 + 1);
    localparam logic [c_TW-1:0] c_LAST_TK  = c_TW'(OVR - 1);
    localparam logic [c_TW-1:0] c_TK_ONE   = c_TW'(1);
    localparam logic [c_BW-1:0] c_LAST_BIT = c_BW'(DATA_BITS - 1);
    localparam logic            c_LAST_STP = 1'(STOP_BITS - 1);

    // Synchroniser
    logic r_sync1, r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    logic w_tick;

    uart_baud_tick #(
        .CLOCK_RATE (CLOCK_RATE),
        .BAUD_RATE  (BAUD_RATE),
        .OVR        (OVR)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    // Receiver state
    rx_state_t            r_state;
    logic [c_TW-1:0]      r_tidx;      // tick within bit; run-length of highs in BREAK
    logic [c_BW-1:0]      r_bidx;
    logic                 r_s0, r_s1;  // first two mid-bit samples
    logic                 r_bit;       // voted value of the current bit
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;       // running XOR of data bits
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_zero;      // every bit so far sampled 0
    logic                 r_stop_idx;

    logic w_samp_a, w_samp_b, w_samp_done, w_bit_end;
    logic w_vote, w_bitval, w_xor, w_perr_calc, w_break;

    always_comb begin
        w_samp_a    = w_tick && (r_tidx == c_SAMP_A);
        w_samp_b    = w_tick && (r_tidx == c_SAMP_B);
        w_samp_done = w_tick && (r_tidx == c_SAMP_C);
        w_bit_end   = w_tick && (r_tidx == c_LAST_TK);
        // Third sample is the live input, so the vote is valid on w_samp_done.
        w_vote      = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
        // With OVR = 4 the last sample and the end of bit share one tick.
        w_bitval    = w_samp_done ? w_vote : r_bit;
        w_xor       = r_par ^ w_vote;
        w_perr_calc = (PARITY == PARITY_EVEN) ? w_xor  :
                      (PARITY == PARITY_ODD)  ? ~w_xor : 1'b0;
        w_break     = (r_stop_idx == 1'b0) && r_zero && !w_vote;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_tidx     <= '0;
            r_bidx     <= '0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_bit      <= 1'b1;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_zero     <= 1'b0;
            r_stop_idx <= 1'b0;
        end else begin
            if (w_samp_a) r_s0 <= r_sync2;
            if (w_samp_b) r_s1 <= r_sync2;
            if (w_samp_done) r_bit <= w_vote;

            case (r_state)
                ST_IDLE: begin
                    if (w_tick && !r_sync2) begin
                        // The detecting tick counts as index 0 of the start bit.
                        r_state    <= ST_START;
                        r_tidx     <= c_TK_ONE;
                        r_bidx     <= '0;
                        r_par      <= 1'b0;
                        r_perr     <= 1'b0;
                        r_ferr     <= 1'b0;
                        r_zero     <= 1'b1;
                        r_stop_idx <= 1'b0;
                    end
                end

                ST_START: begin
                    if (w_tick) begin
                        r_tidx <= r_tidx + 1'b1;
                        if (w_bit_end) begin
                            r_state <= w_bitval ? ST_IDLE : ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (w_tick) begin
                        r_tidx <= r_tidx + 1'b1;
                        if (w_samp_done) begin
                            r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                            r_par   <= w_xor;
                            if (w_vote) r_zero <= 1'b0;
                        end
                        if (w_bit_end) begin
                            if (r_bidx == c_LAST_BIT) begin
                                r_state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                            end else begin
                                r_bidx <= r_bidx + 1'b1;
                            end
                        end
                    end
                end

                ST_PARITY: begin
                    if (w_tick) begin
                        r_tidx <= r_tidx + 1'b1;
                        if (w_samp_done) begin
                            r_perr <= w_perr_calc;
                            if (w_vote) r_zero <= 1'b0;
                        end
                        if (w_bit_end) r_state <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (w_tick) begin
                        r_tidx <= r_tidx + 1'b1;
                        if (w_samp_done) begin
                            if (w_break) begin
                                r_state <= ST_BREAK;
                                r_tidx  <= '0;
                            end else if (r_stop_idx == c_LAST_STP) begin
                                // Leave mid-bit so the next start edge is not missed.
                                r_state <= ST_IDLE;
                            end else begin
                                r_ferr     <= r_ferr | ~w_vote;
                                r_stop_idx <= 1'b1;
                            end
                        end
                    end
                end

                ST_BREAK: begin
                    if (w_tick) begin
                        if (r_sync2) begin
                            if (r_tidx == c_LAST_TK) r_state <= ST_IDLE;
                            r_tidx <= r_tidx + 1'b1;
                        end else begin
                            r_tidx <= '0;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Word posting
    logic                 w_post, w_post_perr, w_post_ferr, w_post_brk;
    logic [DATA_BITS-1:0] w_post_data;

    always_comb begin
        w_post      = 1'b0;
        w_post_data = r_shift;
        w_post_perr = r_perr;
        w_post_ferr = r_ferr | ~w_vote;
        w_post_brk  = 1'b0;
        if ((r_state == ST_STOP) && w_samp_done) begin
            if (w_break) begin
                w_post      = 1'b1;
                w_post_data = '0;
                w_post_perr = 1'b0;
                w_post_ferr = 1'b1;
                w_post_brk  = 1'b1;
            end else if (r_stop_idx == c_LAST_STP) begin
                w_post = 1'b1;
            end
        end
    end

    // Output register
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid, r_operr, r_oferr, r_obrk, r_oovr;
    logic                 w_consume;

    assign w_consume = r_valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_operr <= 1'b0;
            r_oferr <= 1'b0;
            r_obrk  <= 1'b0;
            r_oovr  <= 1'b0;
        end else if (w_post && (!r_valid || w_consume)) begin
            r_data  <= w_post_data;
            r_valid <= 1'b1;
            r_operr <= w_post_perr;
            r_oferr <= w_post_ferr;
            r_obrk  <= w_post_brk;
            r_oovr  <= 1'b0;
        end else if (w_post) begin
            // Held word is kept; the new frame is dropped.
            r_oovr <= 1'b1;
        end else if (w_consume) begin
            r_valid <= 1'b0;
            r_oovr  <= 1'b0;
        end
    end

    assign data       = r_data;
    assign valid      = r_valid;
    assign parity_err = r_operr;
    assign frame_err  = r_oferr;
    assign brk        = r_obrk;
    assign overrun    = r_oovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_param
// Description : Self-checking bench for uart_rx_param. Three receivers
//               (8N1, 8E1, 7O2) share clock and reset; each has its own
//               line and ready. Directed table, hand-written corner cases
//               and random frames checked against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int BIT_CLKS = 16;  // OVR * RATE clocks per bit

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
        logic       ovr;
    } word_t;

    typedef struct packed {
        int         d;
        logic [8:0] data;
        logic       pbit;
        logic [1:0] stops;   // bit i = level driven on stop bit i
        word_t      exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rx = 3'b111;
    logic [2:0] ready = 3'b111;
    logic [7:0] data0, data1;
    logic [6:0] data2;
    logic [2:0] v, pe, fe, bk, ov;

    int n_vec = 0;
    int n_err = 0;
    int stab_err = 0;

    always #5 clk = ~clk;

    uart_rx_param #(.CLOCK_RATE(16), .BAUD_RATE(1), .OVR(8), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx[0]), .data(data0), .valid(v[0]),
        .ready(ready[0]), .parity_err(pe[0]), .frame_err(fe[0]), .brk(bk[0]),
        .overrun(ov[0]));

    uart_rx_param #(.CLOCK_RATE(16), .BAUD_RATE(1), .OVR(8), .DATA_BITS(8),
                    .PARITY(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx[1]), .data(data1), .valid(v[1]),
        .ready(ready[1]), .parity_err(pe[1]), .frame_err(fe[1]), .brk(bk[1]),
        .overrun(ov[1]));

    uart_rx_param #(.CLOCK_RATE(16), .BAUD_RATE(1), .OVR(8), .DATA_BITS(7),
                    .PARITY(2), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .rx(rx[2]), .data(data2), .valid(v[2]),
        .ready(ready[2]), .parity_err(pe[2]), .frame_err(fe[2]), .brk(bk[2]),
        .overrun(ov[2]));

    // Per-receiver configuration
    function automatic int nbits(input int d);
        return (d == 2) ? 7 : 8;
    endfunction
    function automatic int pmode(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 2);
    endfunction
    function automatic int nstop(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    function automatic word_t get_word(input int d);
        word_t w;
        case (d)
            0:       w = {{1'b0, data0}, pe[0], fe[0], bk[0], ov[0]};
            1:       w = {{1'b0, data1}, pe[1], fe[1], bk[1], ov[1]};
            default: w = {{2'b00, data2}, pe[2], fe[2], bk[2], ov[2]};
        endcase
        return w;
    endfunction

    function automatic logic [8:0] mask_data(input int d, input logic [8:0] din);
        return din & ((9'd1 << nbits(d)) - 9'd1);
    endfunction

    function automatic logic good_parity(input int d, input logic [8:0] din);
        logic x;
        x = ^mask_data(d, din);
        return (pmode(d) == 1) ? x : ~x;
    endfunction

    // Frame-level reference: what a receiver should report for the frame.
    function automatic word_t model(input int d, input logic [8:0] din,
                                    input logic pbit, input logic [1:0] stops);
        word_t      w;
        logic [8:0] m;
        logic       x;
        m = mask_data(d, din);
        x = (^m) ^ pbit;
        w.data = m;
        w.ovr  = 1'b0;
        w.brk  = 1'b0;
        if (pmode(d) == 1)      w.perr = x;
        else if (pmode(d) == 2) w.perr = ~x;
        else                    w.perr = 1'b0;
        w.ferr = ~stops[0];
        if (nstop(d) == 2 && !stops[1]) w.ferr = 1'b1;
        if (m == 9'd0 && (pmode(d) == 0 || pbit == 1'b0) && !stops[0]) begin
            w.data = 9'd0;
            w.perr = 1'b0;
            w.ferr = 1'b1;
            w.brk  = 1'b1;
        end
        return w;
    endfunction

    // Monitor: capture consumed words and watch held words for stability.
    word_t cap0[$], cap1[$], cap2[$];
    word_t mon_prev[3];
    logic  mon_hold[3] = '{1'b0, 1'b0, 1'b0};
    word_t mw;

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            mw = get_word(d);
            if (rst_n && mon_hold[d] &&
                ({mw.data, mw.perr, mw.ferr, mw.brk} !==
                 {mon_prev[d].data, mon_prev[d].perr, mon_prev[d].ferr, mon_prev[d].brk}))
                stab_err <= stab_err + 1;
            if (rst_n && v[d] && ready[d]) begin
                case (d)
                    0:       cap0.push_back(mw);
                    1:       cap1.push_back(mw);
                    default: cap2.push_back(mw);
                endcase
            end
            mon_prev[d] <= mw;
            mon_hold[d] <= rst_n && v[d] && !ready[d];
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input int d, input logic b);
        rx[d] = b;
        clks(BIT_CLKS);
    endtask

    task automatic send_frame(input int d, input logic [8:0] din, input logic pbit,
                              input logic [1:0] stops);
        drive_bit(d, 1'b0);
        for (int i = 0; i < nbits(d); i++) drive_bit(d, din[i]);
        if (pmode(d) != 0) drive_bit(d, pbit);
        for (int i = 0; i < nstop(d); i++) drive_bit(d, stops[i]);
        rx[d] = 1'b1;
    endtask

    function automatic int qsize(input int d);
        case (d)
            0:       return cap0.size();
            1:       return cap1.size();
            default: return cap2.size();
        endcase
    endfunction

    task automatic wait_word(input int d, output word_t w, output bit ok);
        ok = 1'b0;
        w  = '0;
        for (int i = 0; i < 40 * BIT_CLKS; i++) begin
            if (qsize(d) > 0) begin
                case (d)
                    0:       w = cap0.pop_front();
                    1:       w = cap1.pop_front();
                    default: w = cap2.pop_front();
                endcase
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_word(input string name, input word_t got, input word_t exp,
                              input bit ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: no word within cycle budget, expected data=%h perr=%b ferr=%b brk=%b ovr=%b",
                     name, exp.data, exp.perr, exp.ferr, exp.brk, exp.ovr);
        end else if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got data=%h perr=%b ferr=%b brk=%b ovr=%b, expected data=%h perr=%b ferr=%b brk=%b ovr=%b",
                     name, got.data, got.perr, got.ferr, got.brk, got.ovr,
                     exp.data, exp.perr, exp.ferr, exp.brk, exp.ovr);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[9];
        word_t      w, e;
        bit         ok;
        int         d;
        logic [8:0] din;
        logic       pbit;
        logic [1:0] stops;

        //            dut data    pbit  stops   data    perr  ferr  brk   ovr
        tbl[0] = '{0, 9'h03C, 1'b0, 2'b11, '{9'h03C, 1'b0, 1'b0, 1'b0, 1'b0}};
        tbl[1] = '{1, 9'h03C, 1'b0, 2'b11, '{9'h03C, 1'b0, 1'b0, 1'b0, 1'b0}};
        tbl[2] = '{1, 9'h03C, 1'b1, 2'b11, '{9'h03C, 1'b1, 1'b0, 1'b0, 1'b0}};
        tbl[3] = '{2, 9'h055, 1'b1, 2'b01, '{9'h055, 1'b0, 1'b1, 1'b0, 1'b0}};
        tbl[4] = '{0, 9'h0FF, 1'b0, 2'b10, '{9'h0FF, 1'b0, 1'b1, 1'b0, 1'b0}};
        tbl[5] = '{1, 9'h000, 1'b0, 2'b11, '{9'h000, 1'b0, 1'b0, 1'b0, 1'b0}};
        tbl[6] = '{2, 9'h000, 1'b1, 2'b11, '{9'h000, 1'b0, 1'b0, 1'b0, 1'b0}};
        tbl[7] = '{2, 9'h07F, 1'b1, 2'b11, '{9'h07F, 1'b1, 1'b0, 1'b0, 1'b0}};
        tbl[8] = '{2, 9'h000, 1'b0, 2'b00, '{9'h000, 1'b0, 1'b1, 1'b1, 1'b0}};

        // Reset state
        #1;
        for (int i = 0; i < 3; i++)
            check_val("reset_state", {v[i], get_word(i)}, 32'd0);
        clks(4);
        rst_n = 1'b1;
        clks(2 * BIT_CLKS);

        // Directed table
        foreach (tbl[i]) begin
            send_frame(tbl[i].d, tbl[i].data, tbl[i].pbit, tbl[i].stops);
            wait_word(tbl[i].d, w, ok);
            check_word("table", w, tbl[i].exp, ok);
            clks(2 * BIT_CLKS);
        end

        // Backpressure: word held stable until accepted, valid drops one clk later
        ready[0] = 1'b0;
        send_frame(0, 9'h0A5, 1'b0, 2'b11);
        ok = 1'b0;
        for (int i = 0; i < 4 * BIT_CLKS && !ok; i++) begin
            @(negedge clk);
            ok = v[0];
        end
        check_val("hold_valid_seen", 32'(ok), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("hold_word", {v[0], get_word(0)}, {1'b1, 9'h0A5, 4'b0000});
        end
        @(posedge clk);
        #1;
        ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("valid_drop", 32'(v[0]), 32'd0);
        wait_word(0, w, ok);
        check_word("held_word_consumed", w, '{9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0}, ok);
        clks(BIT_CLKS);

        // Break: long low, a short high glitch, then recovery
        rx[0] = 1'b0;
        clks(12 * BIT_CLKS);
        rx[0] = 1'b1;
        clks(BIT_CLKS / 2);
        rx[0] = 1'b0;
        clks(2 * BIT_CLKS);
        rx[0] = 1'b1;
        clks(2 * BIT_CLKS);
        check_val("break_word_count", 32'(cap0.size()), 32'd1);
        wait_word(0, w, ok);
        check_word("break_word", w, '{9'h000, 1'b0, 1'b1, 1'b1, 1'b0}, ok);
        send_frame(0, 9'h012, 1'b0, 2'b11);
        wait_word(0, w, ok);
        check_word("after_break", w, '{9'h012, 1'b0, 1'b0, 1'b0, 1'b0}, ok);
        clks(2 * BIT_CLKS);

        // Overrun: second back-to-back frame dropped while first is held
        ready[0] = 1'b0;
        send_frame(0, 9'h011, 1'b0, 2'b11);
        send_frame(0, 9'h022, 1'b0, 2'b11);
        clks(BIT_CLKS);
        ready[0] = 1'b1;
        wait_word(0, w, ok);
        check_word("overrun_word", w, '{9'h011, 1'b0, 1'b0, 1'b0, 1'b1}, ok);
        clks(2 * BIT_CLKS);
        check_val("no_second_valid", {v[0], 31'(cap0.size())}, 32'd0);
        send_frame(0, 9'h033, 1'b0, 2'b11);
        wait_word(0, w, ok);
        check_word("overrun_cleared", w, '{9'h033, 1'b0, 1'b0, 1'b0, 1'b0}, ok);
        clks(2 * BIT_CLKS);

        // False start: two-tick low pulse
        rx[0] = 1'b0;
        clks(4);
        rx[0] = 1'b1;
        clks(3 * BIT_CLKS);
        check_val("false_start", {v[0], 31'(cap0.size())}, 32'd0);

        // Asynchronous reset mid-frame with a word held
        ready[0] = 1'b0;
        send_frame(0, 9'h05A, 1'b0, 2'b11);
        clks(2);
        check_val("pre_reset_held", {v[0], get_word(0)}, {1'b1, 9'h05A, 4'b0000});
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        clks(5);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_reset", {v[0], get_word(0)}, 32'd0);
        clks(3);
        rx[0]    = 1'b1;
        ready[0] = 1'b1;
        rst_n    = 1'b1;
        clks(2 * BIT_CLKS);
        send_frame(0, 9'h081, 1'b0, 2'b11);
        wait_word(0, w, ok);
        check_word("after_reset", w, '{9'h081, 1'b0, 1'b0, 1'b0, 1'b0}, ok);
        clks(2 * BIT_CLKS);

        // Random frames against the frame-level model
        for (int n = 0; n < 24; n++) begin
            d    = $urandom_range(0, 2);
            din  = 9'($urandom);
            if ($urandom_range(0, 5) == 0) din = 9'd0;
            pbit = good_parity(d, din) ^ ($urandom_range(0, 3) == 0);
            stops = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11;
            e = model(d, din, pbit, stops);
            send_frame(d, din, pbit, stops);
            wait_word(d, w, ok);
            check_word("random", w, e, ok);
            clks(2 * BIT_CLKS);
        end

        check_val("no_stray_words", 32'(cap0.size() + cap1.size() + cap2.size()), 32'd0);
        check_val("hold_stable", 32'(stab_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
